led_meter_multi: RTL and testbench

//   Parametrised multi-channel LED level meter; successor of the stereo 8-LED meter.
//   Per channel: rectify each signed audio sample and track an instant-attack,

---
 rtl/led_meter_pkg.sv | 33 +++
 rtl/led_meter_channel.sv | 100 ++++++++++
 rtl/led_meter_multi.sv | 46 ++++
 tb/tb_led_meter_multi.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_meter_pkg.sv
// Shared types and helpers for the multi-channel LED level meter.
package led_meter_pkg;

  localparam int unsigned MAX_W    = 32;
  localparam int unsigned MAX_LEDS = 32;

  // Per-channel meter state; fields sized for the widest supported sample.
  typedef struct packed {
    logic [MAX_W-1:0] env;
    logic [MAX_W-1:0] pk;
    logic [MAX_W-1:0] hc;
    logic [MAX_W-1:0] clip_cnt;
  } meter_state_t;

  // LED k threshold: the top LED sits at half of full scale, 6 dB per step below.
  function automatic logic [MAX_W-1:0] threshold(input int unsigned k,
                                                 input int unsigned w,
                                                 input int unsigned n);
    return MAX_W'(1) << (w - 1 - n + k);
  endfunction

  function automatic logic [MAX_LEDS-1:0] thermo(input logic [MAX_W-1:0] env,
                                                 input int unsigned w,
                                                 input int unsigned n);
    logic [MAX_LEDS-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < MAX_LEDS; k++) begin
      if (k < n) t = t | (MAX_LEDS'(env >= threshold(k, w, n)) << k);
    end
    return t;
  endfunction

endpackage

// File: rtl/led_meter_channel.sv
// One meter channel: rectify (S1), envelope/peak/clip update (S2), LED decode (S3).
module led_meter_channel
  import led_meter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned DECAY_SHIFT  = 10,
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter int unsigned CLIP_SAMPLES = 24000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_dot_en,
  output logic [NUM_LEDS-1:0]   o_led,
  output logic                  o_clip
);

  localparam logic [MAX_W-1:0] FULL = (MAX_W'(1) << (DATA_WIDTH - 1)) - MAX_W'(1);
  localparam logic [MAX_W-1:0] HOLD = MAX_W'(HOLD_SAMPLES);
  localparam logic [MAX_W-1:0] CLIP = MAX_W'(CLIP_SAMPLES);

  logic                  v1_q, v1_d, v2_q, v2_d;
  logic [DATA_WIDTH-2:0] abs_q, abs_d;
  logic [DATA_WIDTH-1:0] neg;
  meter_state_t          st_q, st_d;
  logic [MAX_W-1:0]      mag, dec;
  logic [NUM_LEDS-1:0]   bar, pk_bar, dot;
  logic [NUM_LEDS-1:0]   led_q, led_d;
  logic                  clip_q, clip_d;

  always_comb begin
    // S1: rectify; only the most negative code negates to itself and saturates
    neg   = -i_data;
    v1_d  = i_data_valid;
    abs_d = abs_q;
    if (i_data_valid) begin
      if (!i_data[DATA_WIDTH-1])   abs_d = i_data[DATA_WIDTH-2:0];
      else if (neg[DATA_WIDTH-1])  abs_d = '1;
      else                         abs_d = neg[DATA_WIDTH-2:0];
    end

    // S2: decay step never drops below one LSB so the envelope reaches zero
    mag  = MAX_W'(abs_q);
    dec  = st_q.env >> DECAY_SHIFT;
    if (dec == '0) dec = MAX_W'(1);
    v2_d = v1_q;
    st_d = st_q;
    if (v1_q) begin
      if (mag >= st_q.env)        st_d.env = mag;
      else if (st_q.env != '0)    st_d.env = st_q.env - dec;

      if (mag >= st_q.pk) begin
        st_d.pk = mag;
        st_d.hc = HOLD;
      end else if (st_q.hc != '0) begin
        st_d.hc = st_q.hc - MAX_W'(1);
      end else begin
        st_d.pk = st_d.env;
      end

      if (mag == FULL)                st_d.clip_cnt = CLIP;
      else if (st_q.clip_cnt != '0)   st_d.clip_cnt = st_q.clip_cnt - MAX_W'(1);
    end

    // S3: bar plus the single highest LED the held peak reaches
    bar    = NUM_LEDS'(thermo(st_q.env, DATA_WIDTH, NUM_LEDS));
    pk_bar = NUM_LEDS'(thermo(st_q.pk, DATA_WIDTH, NUM_LEDS));
    dot    = pk_bar & ~(pk_bar >> 1);
    led_d  = led_q;
    clip_d = clip_q;
    if (v2_q) begin
      led_d  = bar | (i_dot_en ? dot : '0);
      clip_d = (st_q.clip_cnt != '0);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      abs_q  <= '0;
      st_q   <= '0;
      led_q  <= '0;
      clip_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      abs_q  <= abs_d;
      st_q   <= st_d;
      led_q  <= led_d;
      clip_q <= clip_d;
    end
  end

  assign o_led  = led_q;
  assign o_clip = clip_q;

endmodule

// File: rtl/led_meter_multi.sv
// Multi-channel LED level meter: splits the packed sample bus across channel meters.
module led_meter_multi
  import led_meter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned DECAY_SHIFT  = 10,
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter int unsigned CLIP_SAMPLES = 24000
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_data,
  input  logic                               i_data_valid,
  input  logic                               i_dot_en,
  output logic [NUM_CHANNELS*NUM_LEDS-1:0]   o_led,
  output logic [NUM_CHANNELS-1:0]            o_clip
);

  if (DATA_WIDTH < NUM_LEDS + 1) begin : g_bad_leds
    $error("led_meter_multi: DATA_WIDTH-1 must be >= NUM_LEDS");
  end
  if (DATA_WIDTH > MAX_W + 1 || NUM_LEDS > MAX_LEDS) begin : g_bad_size
    $error("led_meter_multi: DATA_WIDTH or NUM_LEDS exceeds package limits");
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    led_meter_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_LEDS    (NUM_LEDS),
      .DECAY_SHIFT (DECAY_SHIFT),
      .HOLD_SAMPLES(HOLD_SAMPLES),
      .CLIP_SAMPLES(CLIP_SAMPLES)
    ) u_ch (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_data      (i_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .i_data_valid(i_data_valid),
      .i_dot_en    (i_dot_en),
      .o_led       (o_led[c*NUM_LEDS +: NUM_LEDS]),
      .o_clip      (o_clip[c])
    );
  end

endmodule

// File: tb/tb_led_meter_multi.sv
// Scoreboard bench for led_meter_multi (4 channels, 12 LEDs) against a sample-level model.
module tb_led_meter_multi;

  localparam int W = 24, NC = 4, NL = 12, DS = 10, HOLD = 4800, CLIP = 24000;
  localparam longint FULL = (longint'(1) <<< (W - 1)) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, vld, den;
  logic [NC*W-1:0]   din;
  logic [NC*NL-1:0]  led;
  logic [NC-1:0]     clip;

  led_meter_multi #(
    .DATA_WIDTH(W), .NUM_CHANNELS(NC), .NUM_LEDS(NL),
    .DECAY_SHIFT(DS), .HOLD_SAMPLES(HOLD), .CLIP_SAMPLES(CLIP)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_data(din), .i_data_valid(vld),
    .i_dot_en(den), .o_led(led), .o_clip(clip)
  );

  typedef struct {
    logic [NC*NL-1:0] bar;
    logic [NC*NL-1:0] dot;
    logic [NC-1:0]    clip;
  } exp_t;

  exp_t             exp_q[$];
  logic [NC*NL-1:0] obs_led[$];
  logic [NC-1:0]    obs_clip[$];
  logic [NC*NL-1:0] seqa[$];
  logic [NC*W-1:0]  smp[300];
  int checks = 0, failures = 0;
  longint m_env[NC], m_pk[NC], m_hc[NC], m_cc[NC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_env[c] = 0; m_pk[c] = 0; m_hc[c] = 0; m_cc[c] = 0;
    end
  endtask

  // Sample-level reference: rectify, follow the envelope/peak/clip rules, then bucket into LEDs.
  function automatic exp_t model_step(input logic [NC*W-1:0] d);
    exp_t e;
    e.bar = '0; e.dot = '0; e.clip = '0;
    for (int c = 0; c < NC; c++) begin
      logic signed [W-1:0] s;
      longint x, a, dc, t;
      int top;
      s = W'(d >> (c * W));
      x = longint'(s);
      a = (x < 0) ? -x : x;
      if (a > FULL) a = FULL;
      if (a >= m_env[c]) m_env[c] = a;
      else if (m_env[c] > 0) begin
        dc = m_env[c] / (longint'(1) <<< DS);
        if (dc < 1) dc = 1;
        m_env[c] = m_env[c] - dc;
      end
      if (a >= m_pk[c]) begin m_pk[c] = a; m_hc[c] = HOLD; end
      else if (m_hc[c] != 0) m_hc[c] = m_hc[c] - 1;
      else m_pk[c] = m_env[c];
      if (a == FULL) m_cc[c] = CLIP;
      else if (m_cc[c] > 0) m_cc[c] = m_cc[c] - 1;
      top = -1;
      for (int k = 0; k < NL; k++) begin
        t = longint'(1) <<< (W - 1 - NL + k);
        if (m_env[c] >= t) e.bar = e.bar | ((NC*NL)'(1) << (c * NL + k));
        if (m_pk[c] >= t) top = k;
      end
      if (top >= 0) e.dot = e.dot | ((NC*NL)'(1) << (c * NL + top));
      if (m_cc[c] > 0) e.clip = e.clip | (NC'(1) << c);
    end
    return e;
  endfunction

  function automatic logic [NC*W-1:0] rnd_vec();
    logic [NC*W-1:0] d;
    logic [W-1:0] v;
    d = '0;
    for (int c = 0; c < NC; c++) begin
      v = W'($urandom);
      v = W'($signed(v) >>> $urandom_range(0, W - 1));
      if ($urandom_range(0, 63) == 0) v = {1'b1, {(W-1){1'b0}}};
      d = d | ((NC*W)'(v) << (c * W));
    end
    return d;
  endfunction

  task automatic send(input logic [NC*W-1:0] d, input int gap);
    vld = 1'b1;
    din = d;
    exp_q.push_back(model_step(d));
    @(posedge clk); #1;
    vld = 1'b0;
    din = rnd_vec();
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    vld = 1'b1;
    for (int i = 0; i < n; i++) begin
      din = rnd_vec();
      @(posedge clk); #1;
    end
    rst = 1'b0;
    vld = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic obs_led_chk(input string name, input int idx, input int c,
                             input logic [NL-1:0] mask, input logic [NL-1:0] expv);
    logic [NL-1:0] f;
    if (idx >= obs_led.size()) begin
      checks++; failures++;
      $display("FAIL %s: sample %0d missing, only %0d observed", name, idx, obs_led.size());
    end else begin
      f = NL'(obs_led[idx] >> (c * NL)) & mask;
      check(name, 64'(f), 64'(expv));
    end
  endtask

  task automatic obs_clip_chk(input string name, input int idx, input int c, input logic expv);
    logic f;
    if (idx >= obs_clip.size()) begin
      checks++; failures++;
      $display("FAIL %s: sample %0d missing, only %0d observed", name, idx, obs_clip.size());
    end else begin
      f = 1'(obs_clip[idx] >> c);
      check(name, 64'(f), 64'(expv));
    end
  endtask

  // Monitor: outputs change only three clocks after an accepted valid, otherwise hold.
  initial begin
    logic [2:0]       pipe;
    logic             rs, vin, de, tok;
    logic [NC*NL-1:0] pled, el;
    logic [NC-1:0]    pclip;
    exp_t             e;
    pipe = '0; pled = '0; pclip = '0;
    forever begin
      @(posedge clk);
      rs = rst; vin = vld; de = den; tok = 1'b0;
      if (rs) begin
        pipe = '0;
        exp_q.delete();
      end else begin
        pipe = {pipe[1:0], vin};
        tok  = pipe[2];
      end
      @(negedge clk);
      if (rs) begin
        check("reset_led", 64'(led), 64'd0);
        check("reset_clip", 64'(clip), 64'd0);
      end else if (tok) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: got led %h with no sample pending", led);
        end else begin
          e  = exp_q.pop_front();
          el = e.bar | (de ? e.dot : '0);
          check("led", 64'(led), 64'(el));
          check("clip", 64'(clip), 64'(e.clip));
          obs_led.push_back(led);
          obs_clip.push_back(clip);
        end
      end else begin
        check("hold_led", 64'(led), 64'(pled));
        check("hold_clip", 64'(clip), 64'(pclip));
      end
      pled  = led;
      pclip = clip;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NC*W-1:0] d;
    int m;
    rst = 1'b1; vld = 1'b0; den = 1'b0; din = '0;
    model_reset();

    // Reset with valids pending, then exact three-cycle latency of the first sample
    do_reset(5);
    vld = 1'b1;
    din = {NC{24'h400000}};
    exp_q.push_back(model_step(din));
    @(posedge clk); #1;
    vld = 1'b0;
    @(negedge clk); check("lat_cycle1", 64'(led), 64'd0);
    @(negedge clk); check("lat_cycle2", 64'(led), 64'd0);
    @(negedge clk); check("lat_cycle3", 64'(led), 64'({NC{12'hFFF}}));
    drain();

    // Directed: full-scale decay, peak-dot hold, clip hold and re-clip
    do_reset(2);
    obs_led.delete(); obs_clip.delete();
    den = 1'b1;
    for (int n = 0; n <= 36100; n++) begin
      d = '0;
      if (n == 0) d = {24'h800000, 24'h800000, 24'h200000, 24'h400000};
      if (n == 12000) d = {24'h000000, 24'h800000, 24'h000000, 24'h000000};
      send(d, 0);
    end
    drain();
    obs_led_chk("ch0_full_bar", 0, 0, 12'hFFF, 12'hFFF);
    obs_led_chk("ch1_first_bar", 0, 1, 12'hFFF, 12'h7FF);
    obs_led_chk("ch0_bit10_at600", 600, 0, 12'h400, 12'h400);
    obs_led_chk("ch0_bit10_at800", 800, 0, 12'h400, 12'h000);
    obs_led_chk("ch1_dot_held", 4800, 1, 12'h400, 12'h400);
    obs_led_chk("ch1_dot_released", 4801, 1, 12'h400, 12'h000);
    obs_clip_chk("ch0_no_clip", 0, 0, 1'b0);
    obs_clip_chk("ch3_clip_last", 23999, 3, 1'b1);
    obs_clip_chk("ch3_clip_clear", 24000, 3, 1'b0);
    obs_clip_chk("ch2_reclip_last", 35999, 2, 1'b1);
    obs_clip_chk("ch2_reclip_clear", 36000, 2, 1'b0);

    // Gapped valids must yield the same per-sample sequence as back-to-back
    for (int i = 0; i < 300; i++) smp[i] = rnd_vec();
    do_reset(2);
    obs_led.delete(); obs_clip.delete();
    for (int i = 0; i < 300; i++) send(smp[i], 9);
    drain();
    seqa = obs_led;
    do_reset(2);
    obs_led.delete(); obs_clip.delete();
    for (int i = 0; i < 300; i++) send(smp[i], 0);
    drain();
    check("gap_seq_len", 64'(obs_led.size()), 64'(seqa.size()));
    m = (obs_led.size() < seqa.size()) ? obs_led.size() : seqa.size();
    for (int i = 0; i < m; i++) check("gap_seq", 64'(obs_led[i]), 64'(seqa[i]));

    // Random stream with gaps, dot toggling and a mid-stream reset
    do_reset(2);
    den = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 49) == 0) den = ~den;
      if (n == 2500) do_reset(2);
      send(rnd_vec(), $urandom_range(0, 3));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
